// File: rtl/mmio_fabric.sv
// Memory-mapped interconnect between the CPU data port and up to 2^SEL_BITS
// peripherals. The top SEL_BITS address bits select one slave strobe. Each
// transaction waits for the slave's ready, times out into a bus error, and
// reports unmapped selects as bus errors without strobing any slave.
module mmio_fabric #(
    parameter int unsigned SEL_BITS   = 3,
    parameter int unsigned NUM_SLAVES = 8,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     m_req,
    input  logic [31:0]              m_addr,
    input  logic [31:0]              m_wdata,
    input  logic [3:0]               m_wenable,
    output logic                     m_ready,
    output logic [31:0]              m_rdata,
    output logic                     m_err,
    output logic [NUM_SLAVES-1:0]    s_sel,
    output logic [ADDR_W-1:0]        s_addr,
    output logic [31:0]              s_wdata,
    output logic [3:0]               s_wenable,
    input  logic [NUM_SLAVES*32-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    output logic [7:0]               err_count,
    output logic [31:0]              err_addr
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    // Last counter value before the wait gives up.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wen_q;
    logic [SEL_BITS-1:0]   idx_q;
    logic                  err_q;
    logic [7:0]            cnt_q;
    logic [31:0]           rdata_q;
    logic [7:0]            err_count_q;
    logic [31:0]           err_addr_q;

    logic [SEL_BITS-1:0]   req_idx;
    logic                  req_mapped;
    logic                  sel_ready;
    logic [31:0]           sel_rdata;
    logic                  timeout_hit;

    assign req_idx     = m_addr[31:32-SEL_BITS];
    assign req_mapped  = 32'(req_idx) < NUM_SLAVES;
    assign timeout_hit = (cnt_q == TimeoutLast);

    // Pick the ready and read data of the latched slave; other slaves are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (32'(idx_q) == i) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[32*i +: 32];
            end
        end
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (m_req) begin
                    state_d = req_mapped ? StAccess : StResp;
                end
            end
            StAccess: begin
                if (sel_ready || timeout_hit) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state; strobe and enables only live in ACCESS.
    always_comb begin
        m_ready   = (state_q == StResp);
        s_sel     = '0;
        s_wenable = 4'b0000;
        if (state_q == StAccess) begin
            s_wenable = wen_q;
            for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
                if (32'(idx_q) == i) begin
                    s_sel[i] = 1'b1;
                end
            end
        end
    end

    // Transaction latches, wait counter, response data and error bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wen_q       <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_count_q <= '0;
            err_addr_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (m_req) begin
                        addr_q  <= m_addr;
                        wdata_q <= m_wdata;
                        wen_q   <= m_wenable;
                        idx_q   <= req_idx;
                        cnt_q   <= '0;
                        if (!req_mapped) begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end
                    end
                end
                StAccess: begin
                    // A ready on the final wait cycle still wins over the timeout.
                    if (sel_ready) begin
                        rdata_q <= sel_rdata;
                        err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StResp: begin
                    if (err_q) begin
                        err_addr_q <= addr_q;
                        if (err_count_q != 8'hFF) begin
                            err_count_q <= err_count_q + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_rdata   = rdata_q;
    assign m_err     = err_q;
    assign s_addr    = addr_q[ADDR_W-1:0];
    assign s_wdata   = wdata_q;
    assign err_count = err_count_q;
    assign err_addr  = err_addr_q;

endmodule
